phys_mem_ctrl: RTL and testbench

//  Responder end of the CPU dev_mem_* physical memory port: accepts word accesses from the MMU side and drives one

---
 rtl/phys_mem_ctrl_pkg.sv | 34 +++
 rtl/phys_mem_ctrl_wbuf.sv | 51 +++++
 rtl/phys_mem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_phys_mem_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// phys_mem_ctrl_pkg
//   Shared types for the physical memory controller: FSM state encoding,
//   request / completion-tag layout and a small helper for sizing the
//   strobe-timing counter.
// ---------------------------------------------------------------------------
package phys_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } pm_state_t;

  // One CPU request as seen on the dev_mem_* port (byte lane bits dropped).
  typedef struct packed {
    logic [29:0] word_addr;
    logic        is_write;
    logic [31:0] wdata;
  } pm_req_t;

  // Completion tag: the last request that has been satisfied.
  typedef struct packed {
    logic    valid;
    pm_req_t req;
  } pm_tag_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phys_mem_ctrl_wbuf.sv
// ---------------------------------------------------------------------------
// phys_mem_ctrl_wbuf
//   One-entry posted write buffer. Only present when PHYS_MEM_POSTED_WRITE_EN
//   is defined; otherwise this file contributes no module.
// Ports
//   clk, rst   clock, synchronous active-high reset (empties the buffer)
//   i_load     capture i_addr/i_data and mark the buffer full
//   i_drain    the controller has finished writing the entry to SRAM
//   o_full     entry pending
//   o_addr     buffered SRAM word address
//   o_data     buffered write data
// ---------------------------------------------------------------------------
`ifdef PHYS_MEM_POSTED_WRITE_EN
module phys_mem_ctrl_wbuf #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_data,
  input  logic              i_drain,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_data
);

  logic              r_full;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_addr <= i_addr;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule
`endif

// File: rtl/phys_mem_ctrl.sv
// ---------------------------------------------------------------------------
// phys_mem_ctrl
//   Responder end of the CPU dev_mem_* physical memory port. Serves word
//   accesses against one asynchronous SRAM bank with programmable read and
//   write strobe widths. The CPU presents a request every cycle with no valid
//   strobe; a request equal to the completion tag is satisfied (busy=0),
//   anything else is a miss that starts an SRAM access.
//   Optional macro PHYS_MEM_POSTED_WRITE_EN adds a one-entry posted write
//   buffer so an in-range write miss completes with zero wait.
// Parameters
//   ADDR_W        SRAM word-address width (2..29)
//   READ_CYCLES   cycles oe_n is held low before read data is sampled (>=1)
//   WRITE_CYCLES  cycles we_n is held low per write (>=1)
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dev_mem_addr      byte address from CPU ([1:0] ignored)
//   dev_mem_data_out  CPU write data
//   dev_mem_is_write  1 = write, 0 = read
//   dev_mem_data_in   registered read data to CPU
//   dev_mem_busy      combinational stall: CPU must hold its request
//   sram_addr         SRAM word address
//   sram_dq_out       write data to pad
//   sram_dq_in        read data from pad
//   sram_dq_oe        pad output enable (tristate lives at top level)
//   sram_ce_n/oe_n/we_n  active-low SRAM strobes
// ---------------------------------------------------------------------------
module phys_mem_ctrl
  import phys_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       dev_mem_addr,
  input  logic [31:0]       dev_mem_data_out,
  input  logic              dev_mem_is_write,
  output logic [31:0]       dev_mem_data_in,
  output logic              dev_mem_busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_dq_out,
  input  logic [31:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam int CNT_W = $clog2(max_int(READ_CYCLES, WRITE_CYCLES)) + 1;

  pm_state_t         r_state;
  pm_state_t         w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  pm_tag_t           r_tag;
  pm_req_t           r_req;
  pm_req_t           w_req;

  logic              w_hit;
  logic              w_oor;
  logic              w_cnt_last;
  logic              w_start;
  logic              w_rd_done;
  logic              w_wr_done;
  logic              w_oor_done;
  logic              w_post_accept;
  logic              w_wr_phase;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [31:0]       w_wr_data;
  logic              w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^dev_mem_addr[1:0];

  assign w_req      = {dev_mem_addr[31:2], dev_mem_is_write, dev_mem_data_out};
  assign w_hit      = r_tag.valid && (r_tag.req == w_req);
  assign w_oor      = |dev_mem_addr[31:ADDR_W+2];
  assign w_cnt_last = (r_cnt == '0);
  assign w_start    = (r_state == ST_IDLE) && (w_next_state != ST_IDLE);
  assign w_rd_done  = (r_state == ST_RD) && w_cnt_last;
  assign w_wr_done  = (r_state == ST_WR_HOLD);
  // Out-of-range misses complete in IDLE without touching the SRAM.
  assign w_oor_done = (r_state == ST_IDLE) && !w_hit && w_oor;
  assign w_wr_phase = (r_state == ST_WR_SETUP) || (r_state == ST_WR_PULSE) ||
                      (r_state == ST_WR_HOLD);

`ifdef PHYS_MEM_POSTED_WRITE_EN
  logic w_wbuf_full;

  // The buffer is only ever full while the FSM drains it, so an IDLE FSM
  // implies an empty buffer; the explicit term keeps the handshake honest.
  assign w_post_accept = (r_state == ST_IDLE) && !w_hit && !w_oor &&
                         dev_mem_is_write && !w_wbuf_full;
  // Hits complete during a drain (the posted write itself, held by the CPU);
  // every other miss waits until the drain has reached IDLE.
  assign dev_mem_busy  = w_hit ? ((r_state != ST_IDLE) && !w_wbuf_full)
                               : !w_post_accept;

  phys_mem_ctrl_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_post_accept),
    .i_addr  (dev_mem_addr[ADDR_W+1:2]),
    .i_data  (dev_mem_data_out),
    .i_drain (w_wr_done),
    .o_full  (w_wbuf_full),
    .o_addr  (w_wr_addr),
    .o_data  (w_wr_data)
  );
`else
  assign w_post_accept = 1'b0;
  assign dev_mem_busy  = !w_hit || (r_state != ST_IDLE);
  assign w_wr_addr     = r_req.word_addr[ADDR_W-1:0];
  assign w_wr_data     = r_req.wdata;
`endif

  assign sram_addr   = w_wr_phase ? w_wr_addr : r_req.word_addr[ADDR_W-1:0];
  assign sram_dq_out = w_wr_data;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignment so every register samples the
    // pre-edge value of every other register regardless of process order.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can
    // leave it unassigned and infer a latch.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (!w_hit && !w_oor)
                     w_next_state = dev_mem_is_write ? ST_WR_SETUP : ST_RD;
      ST_RD:       if (w_cnt_last) w_next_state = ST_IDLE;
      ST_WR_SETUP: w_next_state = ST_WR_PULSE;
      ST_WR_PULSE: if (w_cnt_last) w_next_state = ST_WR_HOLD;
      ST_WR_HOLD:  w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  // Strobe outputs, decoded from the current state only.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    case (r_state)
      ST_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      ST_WR_SETUP, ST_WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      ST_WR_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
      end
      default: ;
    endcase
  end

  // Timing counter, request latch, completion tag and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt           <= '0;
      r_req           <= '0;
      r_tag           <= '0;
      dev_mem_data_in <= '0;
    end else begin
      // Reload on every state entry; count down and stick at zero.
      if (r_state != w_next_state) begin
        case (w_next_state)
          ST_RD:       r_cnt <= CNT_W'(READ_CYCLES - 1);
          ST_WR_PULSE: r_cnt <= CNT_W'(WRITE_CYCLES - 1);
          default:     r_cnt <= '0;
        endcase
      end else if (!w_cnt_last) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_start) r_req <= w_req;

      if (w_rd_done) begin
        dev_mem_data_in <= sram_dq_in;
        r_tag           <= {1'b1, r_req};
      end
      if (w_wr_done) r_tag <= {1'b1, r_req};
      if (w_oor_done || w_post_accept) begin
        r_tag <= {1'b1, w_req};
        if (w_oor_done && !dev_mem_is_write) dev_mem_data_in <= '0;
      end
    end
  end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_phys_mem_ctrl
//   Directed bench for phys_mem_ctrl (READ_CYCLES=2, WRITE_CYCLES=2,
//   ADDR_W=20) with a behavioural asynchronous SRAM model. The driver pushes
//   each request's expected busy-cycle count and read data into a queue; a
//   monitor pops and compares when the DUT drops busy for that request.
// ---------------------------------------------------------------------------
module tb_phys_mem_ctrl;

`ifdef PHYS_MEM_POSTED_WRITE_EN
  localparam int WR_BUSY = 0;
`else
  localparam int WR_BUSY = 5;
`endif

  typedef struct {
    int          busy;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dev_mem_addr;
  logic [31:0] dev_mem_data_out;
  logic        dev_mem_is_write;
  logic [31:0] dev_mem_data_in;
  logic        dev_mem_busy;
  logic [19:0] sram_addr;
  logic [31:0] sram_dq_out;
  logic [31:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t  exp_q[$];
  string name_q[$];
  int    seq       = 0;
  int    done_seq  = 0;
  int    mon_seq   = 0;
  int    busy_cnt  = 0;
  bit    mon_done  = 1'b0;
  bit    mon_en    = 1'b1;
  exp_t  mon_e;
  string mon_name;
  int    ce_cnt = 0;
  int    oe_cnt = 0;
  int    we_cnt = 0;

  // NOTE: SRAM contents are never reset, like the real part; only the
  // controller's control state is.
  logic [31:0] mem [logic [19:0]];

  phys_mem_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .dev_mem_addr     (dev_mem_addr),
    .dev_mem_data_out (dev_mem_data_out),
    .dev_mem_is_write (dev_mem_is_write),
    .dev_mem_data_in  (dev_mem_data_in),
    .dev_mem_busy     (dev_mem_busy),
    .sram_addr        (sram_addr),
    .sram_dq_out      (sram_dq_out),
    .sram_dq_in       (sram_dq_in),
    .sram_dq_oe       (sram_dq_oe),
    .sram_ce_n        (sram_ce_n),
    .sram_oe_n        (sram_oe_n),
    .sram_we_n        (sram_we_n)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // SRAM model and strobe counters, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!sram_ce_n) ce_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_addr] = sram_dq_out;
      check("dq_oe_during_we", 32'(sram_dq_oe), 32'd1);
    end
    sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : 32'hBAD0_BAD0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && mon_en && seq != 0) begin
      if (seq != mon_seq) begin
        mon_seq  = seq;
        busy_cnt = 0;
        mon_done = 1'b0;
      end
      if (!mon_done) begin
        if (dev_mem_busy) begin
          busy_cnt++;
        end else begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_completion: got completion for seq %0d, required none", seq);
          end else begin
            mon_e    = exp_q.pop_front();
            mon_name = name_q.pop_front();
            check({mon_name, "_busy_cycles"}, 32'(busy_cnt), 32'(mon_e.busy));
            check({mon_name, "_data_in"}, dev_mem_data_in, mon_e.data);
          end
          mon_done = 1'b1;
          done_seq = seq;
        end
      end else begin
        check("held_request_busy", 32'(dev_mem_busy), 32'd0);
      end
    end
  end

  // Present one request, wait for completion, hold it, check strobe counts.
  // A negative strobe expectation skips that count.
  task automatic do_req(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic wr, input int exp_busy, input logic [31:0] exp_data,
                        input int hold, input int exp_ce, input int exp_we, input int exp_oe);
    exp_t e;
    int   ce0, we0, oe0;
    bit   ok;
    e.busy = exp_busy;
    e.data = exp_data;
    exp_q.push_back(e);
    name_q.push_back(name);
    ce0 = ce_cnt;
    we0 = we_cnt;
    oe0 = oe_cnt;
    dev_mem_addr     = addr;
    dev_mem_data_out = wdata;
    dev_mem_is_write = wr;
    seq++;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      if (done_seq == seq) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no completion in 60 cycles, required completion", name);
      exp_q.delete();
      name_q.delete();
    end
    repeat (hold) @(posedge clk);
    #1;
    if (exp_ce >= 0) check({name, "_ce_cycles"}, 32'(ce_cnt - ce0), 32'(exp_ce));
    if (exp_we >= 0) check({name, "_we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
    if (exp_oe >= 0) check({name, "_oe_cycles"}, 32'(oe_cnt - oe0), 32'(exp_oe));
  endtask

  initial begin
    bit seen_we;
    mem[20'h00005] = 32'h1234_5678;

    // Reset held for three edges with an out-of-range read already presented.
    rst              = 1'b1;
    dev_mem_addr     = 32'h8000_0000;
    dev_mem_data_out = 32'h0;
    dev_mem_is_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",     32'(dev_mem_busy), 32'd1);
    check("rst_data_in",  dev_mem_data_in,   32'h0);
    check("rst_ce_n",     32'(sram_ce_n),    32'd1);
    check("rst_oe_n",     32'(sram_oe_n),    32'd1);
    check("rst_we_n",     32'(sram_we_n),    32'd1);
    check("rst_dq_oe",    32'(sram_dq_oe),   32'd0);
    check("rst_sram_addr", 32'(sram_addr),   32'h0);
    check("rst_dq_out",   sram_dq_out,       32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    //     name             addr          wdata         wr    busy     data_in       hold ce we oe
    do_req("oor_read",      32'h8000_0000, 32'h0,        1'b0, 1,       32'h0,        2,   0, 0, 0);
    do_req("wr_10",         32'h0000_0010, 32'hDEAD_BEEF, 1'b1, WR_BUSY, 32'h0,        5,   4, 2, 0);
    check("mem_word4", mem_rd(20'h00004), 32'hDEAD_BEEF);
    do_req("rd_10",         32'h0000_0010, 32'h0,        1'b0, 3,       32'hDEAD_BEEF, 4,   2, 0, 2);
    do_req("rd_14",         32'h0000_0014, 32'h0,        1'b0, 3,       32'h1234_5678, 1,   2, 0, 2);
    do_req("wr_18",         32'h0000_0018, 32'hA5A5_A5A5, 1'b1, WR_BUSY, 32'h1234_5678, 5,   4, 2, 0);
    do_req("wr_18_repeat",  32'h0000_0018, 32'hA5A5_A5A5, 1'b1, 0,       32'h1234_5678, 1,   0, 0, 0);
    do_req("rd_18",         32'h0000_0018, 32'h0,        1'b0, 3,       32'hA5A5_A5A5, 1,   2, 0, 2);
    do_req("oor_write",     32'h0040_0000, 32'hFFFF_FFFF, 1'b1, 1,       32'hA5A5_A5A5, 1,   0, 0, 0);
    do_req("wr_top",        32'h003F_FFFC, 32'h0BAD_F00D, 1'b1, WR_BUSY, 32'hA5A5_A5A5, 5,   4, 2, 0);
    check("mem_word_top", mem_rd(20'hFFFFF), 32'h0BAD_F00D);
    do_req("rd_top",        32'h003F_FFFC, 32'h0,        1'b0, 3,       32'h0BAD_F00D, 1,   2, 0, 2);

    // Reset while the write strobe is low: the access is abandoned at once.
    mon_en           = 1'b0;
    dev_mem_addr     = 32'h0000_0020;
    dev_mem_data_out = 32'h0000_0055;
    dev_mem_is_write = 1'b1;
    seen_we = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        seen_we = 1'b1;
        break;
      end
    end
    check("abort_saw_we_pulse", 32'(seen_we), 32'd1);
    rst              = 1'b1;
    dev_mem_addr     = 32'h003F_FFFC;
    dev_mem_data_out = 32'h0;
    dev_mem_is_write = 1'b0;
    @(negedge clk);
    check("abort_we_n",    32'(sram_we_n),    32'd1);
    check("abort_ce_n",    32'(sram_ce_n),    32'd1);
    check("abort_dq_oe",   32'(sram_dq_oe),   32'd0);
    check("abort_tag_inv", 32'(dev_mem_busy), 32'd1);
    check("abort_data_in", dev_mem_data_in,   32'h0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    do_req("rd_top_post_rst", 32'h003F_FFFC, 32'h0,      1'b0, 3,       32'h0BAD_F00D, 1,   2, 0, 2);

`ifdef PHYS_MEM_POSTED_WRITE_EN
    // Posted writes: first is free, second waits for the drain, read is
    // ordered behind both.
    do_req("pw_20",         32'h0000_0020, 32'h0000_0001, 1'b1, 0,       32'h0BAD_F00D, 0,  -1, -1, -1);
    do_req("pw_24",         32'h0000_0024, 32'h0000_0002, 1'b1, 4,       32'h0BAD_F00D, 0,  -1, -1, -1);
    do_req("pr_20",         32'h0000_0020, 32'h0,        1'b0, 7,       32'h0000_0001, 1,  -1, -1, -1);
    check("mem_word8", mem_rd(20'h00008), 32'h0000_0001);
    check("mem_word9", mem_rd(20'h00009), 32'h0000_0002);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
